sar_search_ctrl: RTL



---
 rtl/sar_search_ctrl_if.sv | 30 +++
 rtl/sar_search_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl_if.sv
// Probe/verdict and start/done signalling between the SAR search controller,
// its magnitude comparator and the surrounding control logic.
interface sar_search_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned STEP_W = $clog2(WIDTH + 2);

  logic              start;
  logic              less;
  logic              equal;
  logic              greater;
  logic [WIDTH-1:0]  probe;
  logic              busy;
  logic              done;
  logic              found;
  logic              error;
  logic [WIDTH-1:0]  result;
  logic [STEP_W-1:0] steps;

  // master: the search controller (initiator toward the comparator)
  modport master (
    input  start, less, equal, greater,
    output probe, busy, done, found, error, result, steps
  );

  modport slave (
    output start, less, equal, greater,
    input  probe, busy, done, found, error, result, steps
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation controller: binary-searches the comparator's A
// operand by driving B (probe) and narrowing [lo, hi] from its verdicts.
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  sar_search_ctrl_if.master bus
);
  localparam int unsigned STEP_W = $clog2(WIDTH + 2);
  localparam int unsigned LW     = WIDTH + 1;
  localparam int unsigned EW     = WIDTH + 2;
  localparam logic [LW-1:0] HI_INIT = LW'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state;
  logic [LW-1:0]     lo;
  logic [LW-1:0]     hi;
  logic [LW-1:0]     sum_c;
  logic [WIDTH-1:0]  probe_c;
  logic [EW-1:0]     lo_up_c;
  logic [EW-1:0]     hi_dn_c;
  logic              over_c;
  logic              under_c;
  logic [2:0]        verdict_c;

  logic              busy_q;
  logic              done_q;
  logic              found_q;
  logic              error_q;
  logic [WIDTH-1:0]  result_q;
  logic [STEP_W-1:0] steps_q;

  assign sum_c   = lo + hi;
  assign probe_c = WIDTH'(sum_c >> 1);

  // Candidate bounds in one extra bit so probe-1 at zero reads as -1
  assign lo_up_c   = EW'(probe_c) + EW'(1);
  assign hi_dn_c   = EW'(probe_c) - EW'(1);
  assign over_c    = $signed(lo_up_c) > $signed(EW'(hi));
  assign under_c   = $signed(EW'(lo)) > $signed(hi_dn_c);
  assign verdict_c = {bus.less, bus.equal, bus.greater};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lo       <= '0;
      hi       <= HI_INIT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            lo       <= '0;
            hi       <= HI_INIT;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            steps_q  <= '0;
            busy_q   <= 1'b1;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          steps_q <= steps_q + STEP_W'(1);
          case (verdict_c)
            3'b010: begin
              result_q <= probe_c;
              found_q  <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state    <= DONE;
            end
            3'b001: begin
              lo <= LW'(lo_up_c);
              if (over_c) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state   <= DONE;
              end
            end
            3'b100: begin
              hi <= LW'(hi_dn_c);
              if (under_c) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state   <= DONE;
              end
            end
            default: begin
              // No verdict or conflicting verdicts: bounds left untouched
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end
          endcase
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.probe  = probe_c;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.error  = error_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;
endmodule
